// File: rtl/l2_way_array.sv
// Multi-way L2 storage array: one read port returning every way of a set, a byte-masked
// per-way write port with read-during-write bypass, and a one-set-per-cycle clear sweep.
// Optional per-byte even parity when L2_ARRAY_PARITY_EN is defined.
module l2_way_array #(
    parameter int s_index  = 3,
    parameter int width    = 256,
    parameter int num_ways = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    output logic                      busy,
    input  logic                      read,
    input  logic [s_index-1:0]        rindex,
    output logic                      rvalid,
    output logic [num_ways*width-1:0] dataout,
    input  logic [num_ways-1:0]       load,
    input  logic [s_index-1:0]        windex,
    input  logic [width/8-1:0]        wmask,
    input  logic [width-1:0]          datain,
    output logic [num_ways-1:0]       perr
);
    localparam int num_sets = 2 ** s_index;
    localparam int nbytes   = width / 8;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t             state_reg, state_next;
    logic [s_index-1:0] cidx_reg, cidx_next;
    logic               rvalid_reg;
    logic               rd_en;
    logic [num_ways-1:0] wr_en;

    logic [width-1:0] mem_reg [num_sets][num_ways];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= CLEAR;
            cidx_reg  <= '0;
        end else begin
            state_reg <= state_next;
            cidx_reg  <= cidx_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cidx_next  = cidx_reg;
        case (state_reg)
            IDLE: begin
                if (clr) begin
                    state_next = CLEAR;
                    cidx_next  = '0;
                end
            end
            CLEAR: begin
                cidx_next = cidx_reg + 1'b1;
                if (&cidx_reg) state_next = IDLE;
            end
            default: state_next = CLEAR;
        endcase
    end

    // busy is a pure decode of the state register, so it never depends on inputs
    assign busy   = (state_reg == CLEAR);
    assign rd_en  = read & ~busy & ~rst;
    assign wr_en  = load & {num_ways{~busy & ~rst}};
    assign rvalid = rvalid_reg;

    always_ff @(posedge clk) begin
        if (rst) rvalid_reg <= 1'b0;
        else     rvalid_reg <= rd_en;
    end

    always_ff @(posedge clk) begin
        for (int w = 0; w < num_ways; w++) begin
            if (busy) begin
                mem_reg[cidx_reg][w] <= '0;
            end else if (wr_en[w]) begin
                for (int b = 0; b < nbytes; b++) begin
                    if (wmask[b]) mem_reg[windex][w][b*8 +: 8] <= datain[b*8 +: 8];
                end
            end
        end
    end

`ifdef L2_ARRAY_PARITY_EN
    logic [nbytes-1:0] par_reg [num_sets][num_ways];

    always_ff @(posedge clk) begin
        for (int w = 0; w < num_ways; w++) begin
            if (busy) begin
                par_reg[cidx_reg][w] <= '0;
            end else if (wr_en[w]) begin
                for (int b = 0; b < nbytes; b++) begin
                    if (wmask[b]) par_reg[windex][w][b] <= ^datain[b*8 +: 8];
                end
            end
        end
    end
`endif

    genvar gi;
    generate
        for (gi = 0; gi < num_ways; gi++) begin : g_way
            logic             byp;
            logic [width-1:0] rd_word;
            logic [width-1:0] dout_reg;

            assign byp = load[gi] && (rindex == windex);

            // Bytes being written this cycle are taken straight from datain
            always_comb begin
                rd_word = '0;
                for (int b = 0; b < nbytes; b++) begin
                    rd_word[b*8 +: 8] = (byp && wmask[b]) ? datain[b*8 +: 8]
                                                          : mem_reg[rindex][gi][b*8 +: 8];
                end
            end

            always_ff @(posedge clk) begin
                if (rst)        dout_reg <= '0;
                else if (rd_en) dout_reg <= rd_word;
            end

            assign dataout[gi*width +: width] = dout_reg;

`ifdef L2_ARRAY_PARITY_EN
            logic perr_bit;
            logic perr_reg;

            // Bypassed bytes carry freshly generated parity, so they cannot fail
            always_comb begin
                perr_bit = 1'b0;
                for (int b = 0; b < nbytes; b++) begin
                    if (!(byp && wmask[b]) &&
                        ((^mem_reg[rindex][gi][b*8 +: 8]) != par_reg[rindex][gi][b]))
                        perr_bit = 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (rst)        perr_reg <= 1'b0;
                else if (rd_en) perr_reg <= perr_bit;
            end

            assign perr[gi] = perr_reg;
`else
            assign perr[gi] = 1'b0;
`endif
        end
    endgenerate
endmodule

// File: tb/tb_l2_way_array.sv
// Scoreboard bench for l2_way_array (s_index=3, width=32, num_ways=2): a reference model
// pushes expected read results at the accepting edge; they are popped when rvalid appears.
module tb_l2_way_array;
    logic        clk = 1'b0;
    logic        rst, clr, busy, read, rvalid;
    logic [2:0]  rindex, windex;
    logic [63:0] dataout;
    logic [1:0]  load, perr;
    logic [3:0]  wmask;
    logic [31:0] datain;

    l2_way_array #(.s_index(3), .width(32), .num_ways(2)) dut (
        .clk(clk), .rst(rst), .clr(clr), .busy(busy), .read(read), .rindex(rindex),
        .rvalid(rvalid), .dataout(dataout), .load(load), .windex(windex),
        .wmask(wmask), .datain(datain), .perr(perr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] d;
        logic [1:0]  p;
    } rd_t;

    rd_t         q[$];
    logic [31:0] mmem [8][2];
    logic [3:0]  mpar [8][2];
    logic        mbusy = 1'b0;
    logic [2:0]  mcidx = '0;
    logic [63:0] mdout = '0;
    logic [1:0]  mperr = '0;
    logic        armed = 1'b0;
    int          checks = 0;
    int          errors = 0;
    int          bcnt;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", tag, act, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic [2:0] ri, input logic [1:0] ld,
                              input logic [2:0] wi, input logic [3:0] wm, input logic [31:0] d,
                              input logic c, input logic rs);
        logic [63:0] ed;
        logic [1:0]  ep;
        logic        bp;
        if (rs) begin
            q.delete();
            mbusy = 1'b1;
            mcidx = '0;
            mdout = '0;
            mperr = '0;
            armed = 1'b1;
        end else if (!mbusy) begin
            if (r) begin
                ed = '0;
                ep = '0;
                for (int w = 0; w < 2; w++) begin
                    for (int b = 0; b < 4; b++) begin
                        bp = ld[w] && (ri == wi) && wm[b];
                        ed[w*32 + b*8 +: 8] = bp ? d[b*8 +: 8] : mmem[ri][w][b*8 +: 8];
`ifdef L2_ARRAY_PARITY_EN
                        if (!bp && ((^mmem[ri][w][b*8 +: 8]) != mpar[ri][w][b])) ep[w] = 1'b1;
`endif
                    end
                end
                q.push_back('{d: ed, p: ep});
            end
            for (int w = 0; w < 2; w++) begin
                if (ld[w]) begin
                    for (int b = 0; b < 4; b++) begin
                        if (wm[b]) begin
                            mmem[wi][w][b*8 +: 8] = d[b*8 +: 8];
                            mpar[wi][w][b] = ^d[b*8 +: 8];
                        end
                    end
                end
            end
            if (c) begin
                mbusy = 1'b1;
                mcidx = '0;
            end
        end else begin
            for (int w = 0; w < 2; w++) begin
                mmem[mcidx][w] = '0;
                mpar[mcidx][w] = '0;
            end
            if (mcidx == 3'd7) mbusy = 1'b0;
            mcidx = mcidx + 3'd1;
        end
    endtask

    task automatic cyc(input logic r, input logic [2:0] ri, input logic [1:0] ld,
                       input logic [2:0] wi, input logic [3:0] wm, input logic [31:0] d,
                       input logic c, input logic rs);
        rd_t e;
        read = r; rindex = ri; load = ld; windex = wi; wmask = wm; datain = d;
        clr = c; rst = rs;
        @(posedge clk);
        model_edge(r, ri, ld, wi, wm, d, c, rs);
        #1;
        if (armed) begin
            chk("busy", {63'b0, busy}, {63'b0, mbusy});
            chk("rvalid", {63'b0, rvalid}, {63'b0, (q.size() != 0)});
            if (q.size() != 0) begin
                e = q.pop_front();
                mdout = e.d;
                mperr = e.p;
                $display("read dout=%h perr=%b", dataout, perr);
            end
            chk("dataout", dataout, mdout);
            chk("perr", {62'b0, perr}, {62'b0, mperr});
        end
    endtask

    task automatic idle();
        cyc(1'b0, 3'd0, 2'b00, 3'd0, 4'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic rd(input logic [2:0] i);
        cyc(1'b1, i, 2'b00, 3'd0, 4'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic wr(input logic [1:0] ld, input logic [2:0] i, input logic [3:0] m,
                      input logic [31:0] d);
        cyc(1'b0, 3'd0, ld, i, m, d, 1'b0, 1'b0);
    endtask

    initial begin
        for (int s = 0; s < 8; s++)
            for (int w = 0; w < 2; w++) begin
                mmem[s][w] = '0;
                mpar[s][w] = '0;
            end
        read = 0; rindex = 0; load = 0; windex = 0; wmask = 0; datain = 0; clr = 0; rst = 1;
        @(posedge clk);
        #1;

        // Reset sweep; reads during busy must not be accepted
        cyc(1'b0, 3'd0, 2'b00, 3'd0, 4'h0, 32'h0, 1'b0, 1'b1);
        cyc(1'b0, 3'd0, 2'b00, 3'd0, 4'h0, 32'h0, 1'b0, 1'b1);
        chk("busy_after_rst", {63'b0, busy}, 64'd1);
        for (int i = 0; i < 7; i++) rd(3'(i));
        cyc(1'b1, 3'd0, 2'b00, 3'd0, 4'h0, 32'h0, 1'b0, 1'b0);
        chk("busy_done", {63'b0, busy}, 64'd0);
        for (int i = 0; i < 8; i++) rd(3'(i));
        idle();

        // Masked write to way1 of set 5
        wr(2'b10, 3'd5, 4'b0101, 32'hAABBCCDD);
        rd(3'd5);
        chk("masked_write", dataout, {32'h00BB00DD, 32'h0});
        idle();

        // Read-during-write bypass
        wr(2'b01, 3'd2, 4'hF, 32'h11223344);
        cyc(1'b1, 3'd2, 2'b01, 3'd2, 4'b1000, 32'h99000000, 1'b0, 1'b0);
        chk("bypass", dataout, {32'h0, 32'h99223344});
        rd(3'd2);
        chk("post_bypass", dataout, {32'h0, 32'h99223344});

        // Fill, then clear sweep with ignored traffic
        for (int i = 0; i < 8; i++) wr(2'b11, 3'(i), 4'hF, 32'hFFFFFFFF);
        rd(3'd7);
        cyc(1'b0, 3'd0, 2'b00, 3'd0, 4'h0, 32'h0, 1'b1, 1'b0);
        bcnt = 0;
        for (int i = 0; i < 20 && busy; i++) begin
            bcnt++;
            cyc(1'b1, 3'($urandom_range(0, 7)), 2'b11, 3'($urandom_range(0, 7)), 4'hF,
                $urandom, 1'b0, 1'b0);
        end
        chk("clr_busy_cycles", 64'(bcnt), 64'd8);
        chk("dout_hold", dataout, 64'hFFFFFFFF_FFFFFFFF);
        for (int i = 0; i < 8; i++) rd(3'(i));
        chk("cleared", dataout, 64'h0);
        idle();

        // Reset at sweep cycle 4, second clr during the restarted sweep
        cyc(1'b0, 3'd0, 2'b00, 3'd0, 4'h0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) idle();
        cyc(1'b0, 3'd0, 2'b00, 3'd0, 4'h0, 32'h0, 1'b0, 1'b1);
        bcnt = 0;
        for (int i = 0; i < 20 && busy; i++) begin
            bcnt++;
            cyc(1'b0, 3'd0, 2'b00, 3'd0, 4'h0, 32'h0, (i == 2), 1'b0);
        end
        chk("rst_restart_cycles", 64'(bcnt), 64'd8);
        idle();

        // Parity error from a flipped stored bit
        wr(2'b01, 3'd3, 4'hF, 32'h01010101);
        dut.mem_reg[3][0][0] <= ~dut.mem_reg[3][0][0];
        mmem[3][0][0] = ~mmem[3][0][0];
        idle();
        rd(3'd3);
        chk("flip_data", dataout, {32'h0, 32'h01010100});
`ifdef L2_ARRAY_PARITY_EN
        chk("perr_flip", {62'b0, perr}, 64'd1);
`else
        chk("perr_flip", {62'b0, perr}, 64'd0);
`endif
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/l2_way_array.md
# l2_way_array

Parametrised multi-way data/tag storage array for the L2 cache, replacing the single-way array. It provides one synchronous read port returning all ways of a set, one write port with per-way enables and byte masks, and read-during-write bypass. Contents are cleared by a background sweep (one set per cycle) rather than a single-cycle flush, with a `busy` flag to stall the cache controller. It sits beside the L2 control FSM, one instance each for data, tag and valid/dirty storage.

## Interface
- `s_index`, 3: index bits; `num_sets = 2**s_index`.
- `width`, 256: bits per way entry; must be a multiple of 8.
- `num_ways`, 4: ways per set.
- `clk` input 1: clock, all logic on rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `clr` input 1: request a full-array clear sweep.
- `busy` output 1: clear sweep in progress; reads and writes are ignored.
- `read` input 1: read request for `rindex`.
- `rindex` input s_index: read set index.
- `rvalid` output 1: `dataout` updated by the previous cycle's accepted read.
- `dataout` output num_ways*width: way w occupies bits [w*width +: width].
- `load` input num_ways: per-way write enable.
- `windex` input s_index: write set index.
- `wmask` input width/8: byte enables, shared by all enabled ways.
- `datain` input width: write data, shared by all enabled ways.
- `perr` output num_ways: per-way parity error on the returned data (see Configuration).

## Operation
- The FSM has two states, IDLE and CLEAR, and an s_index-bit sweep counter `cidx`.
- `rst`: state to CLEAR, `cidx`=0, `rvalid`=0, `dataout`=0, `perr`=0. Stored contents are not touched directly; the sweep zeroes them.
- CLEAR: each cycle writes all-zero to every way of set `cidx`, then increments `cidx`. After the cycle that clears `num_sets-1`, the state returns to IDLE. `busy`=1 throughout CLEAR.
- IDLE + `clr`=1: go to CLEAR with `cidx`=0.
- `clr` during CLEAR is ignored; the sweep is not restarted.
- `rst` during CLEAR restarts the sweep from `cidx`=0.
- While `busy`=1, `read`, `load` and `clr` are ignored, and `rvalid` stays 0.
- Write (IDLE): for each way w with `load[w]`=1, byte b of `data[windex][w]` is replaced by `datain` byte b where `wmask[b]`=1. Unmasked bytes and disabled ways are unchanged.
- Read (IDLE, `read`=1): `dataout` is loaded with all ways of `rindex`.
  - If `load[w]` and `rindex==windex` in the same cycle, way w returns the merged post-write value: masked bytes from `datain`, the rest from storage.
- `dataout` holds its last value when no read is accepted. It is not cleared by the sweep.
- Writes and reads to different indices in the same cycle are fully independent.

## Timing
- Read latency is 1 cycle. A read accepted at edge N drives `dataout` and `rvalid`=1 after N. `rvalid` falls after N+1 unless another read is accepted.
- Write latency is 1 cycle. A read issued the cycle after a write sees the new data; a read in the same cycle sees it through the bypass.
- Clear duration: `busy` rises the cycle after `rst` or `clr` and stays high for exactly `num_sets` cycles. The first accepted read or write is in cycle `num_sets+1` after the request.
- `busy` is registered and has no combinational path from any input.

## Configuration
- `L2_ARRAY_PARITY_EN` defined:
  - Each stored byte carries an even-parity bit, written with the data and cleared to 0 by the sweep.
  - On read, `perr[w]`=1 when any byte of way w fails its parity check. `perr` is registered alongside `dataout` and is valid when `rvalid`=1.
  - Bypassed bytes always pass the check.
- `L2_ARRAY_PARITY_EN` not defined:
  - No parity storage.
  - `perr` is constant 0.

## Test plan
- Bench configuration for all scenarios: s_index=3, width=32, num_ways=2.
- Reset sweep: pulse `rst` → `busy`=1 for 8 cycles, then 0. Reads of sets 0..7 return 0 with `rvalid`=1 one cycle after each read. A read issued while `busy`=1 gives `rvalid`=0.
- Masked write: `load`=2'b10, `windex`=5, `wmask`=4'b0101, `datain`=32'hAABBCCDD, then read set 5 → way1=32'h00BB00DD, way0=0.
- Bypass: set 2 way0 holds 32'h11223344. In one cycle issue `read` with `rindex`=2 and `load`=2'b01, `windex`=2, `wmask`=4'b1000, `datain`=32'h99000000 → next cycle way0=32'h99223344. A following read returns the same value.
- Clear after writes: fill all sets with 32'hFFFFFFFF, assert `clr` → 8 busy cycles. `load` and `read` asserted during the sweep have no effect. Afterwards every set reads 0, and `dataout` holds its pre-sweep value until the first read.
- Reset mid-sweep: assert `clr`, assert `rst` at sweep cycle 4 → `busy` stays high for 8 further cycles. A second `clr` during the sweep does not extend it.
- Parity (macro defined): write 32'h01010101 to way0 of set 3, force-flip one stored data bit, read set 3 → `perr`=2'b01 with `rvalid`=1. Without the macro, `perr`=0 for the same sequence.
